// File: rtl/dram_write_ctrl_if.sv
// Bundle of the sizer, merge-stream and DRAM write-port signals around dram_write_ctrl.
// master is the controller's view; slave is the surrounding environment's view.
interface dram_write_ctrl_if #(
  parameter int DATA_W   = 512,
  parameter int FIFO_LOG = 7
);
  logic              pchange;
  logic [31:0]       base_addr;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic [31:0]       w_block;
  logic [31:0]       w_addr;
  logic              mgdrive;
  logic              dram_req;
  logic [31:0]       dram_req_addr;
  logic [31:0]       dram_req_len;
  logic              dram_req_ack;
  logic [DATA_W-1:0] dram_wdata;
  logic              dram_wvalid;
  logic              dram_wready;
  logic [FIFO_LOG:0] fifo_cnt;

  modport master (
    input  pchange, base_addr, din, din_valid, w_block, dram_req_ack, dram_wready,
    output din_ready, w_addr, mgdrive, dram_req, dram_req_addr, dram_req_len,
           dram_wdata, dram_wvalid, fifo_cnt
  );

  modport slave (
    output pchange, base_addr, din, din_valid, w_block, dram_req_ack, dram_wready,
    input  din_ready, w_addr, mgdrive, dram_req, dram_req_addr, dram_req_len,
           dram_wdata, dram_wvalid, fifo_cnt
  );
endinterface

// File: rtl/dram_write_ctrl.sv
// Buffers merged words in a FIFO and issues DRAM write bursts of the sizer-requested
// length, advancing the write address and pulsing mgdrive once per accepted burst.
module dram_write_ctrl #(
  parameter int DATA_W      = 512,
  parameter int WORD_BYTES  = 64,
  parameter int FIFO_LOG    = 7,
  parameter int MAX_WBLOCKS = 16,
  parameter int ADDR_INIT   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  dram_write_ctrl_if.master     io_bus
);

  localparam int DEPTH = 1 << FIFO_LOG;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DATA} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [FIFO_LOG-1:0] r_wr;
  logic [FIFO_LOG-1:0] r_rd;
  logic [FIFO_LOG:0] r_cnt;
  logic [FIFO_LOG:0] r_beats;
  logic [31:0]       r_w_addr;
  logic [31:0]       r_req_addr;
  logic [31:0]       r_req_len;
  logic              r_pend;

  logic        w_req;
  logic        w_mg;
  logic        w_wvalid;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_last;
  logic        w_launch;
  logic [31:0] w_len_eff;

  // Clamp the sizer's request into the burst range the FIFO can always satisfy.
  always_comb begin
    w_len_eff = io_bus.w_block;
    if (io_bus.w_block == 32'd0)
      w_len_eff = 32'd1;
    else if (io_bus.w_block > 32'(MAX_WBLOCKS))
      w_len_eff = 32'(MAX_WBLOCKS);
  end

  assign w_full   = (r_cnt == (FIFO_LOG+1)'(DEPTH));
  assign w_pop    = w_wvalid && io_bus.dram_wready;
  assign w_push   = io_bus.din_valid && io_bus.din_ready;
  assign w_last   = w_pop && (r_beats == (FIFO_LOG+1)'(1));
  assign w_launch = (32'(r_cnt) >= w_len_eff);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_mg        = 1'b0;
    w_wvalid    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_launch) w_state_nxt = ST_REQ;
      ST_REQ: begin
        w_req = 1'b1;
        if (io_bus.dram_req_ack) begin
          w_mg        = 1'b1;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        w_wvalid = 1'b1;
        if (io_bus.dram_wready && (r_beats == (FIFO_LOG+1)'(1))) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= io_bus.din;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_beats    <= '0;
      r_w_addr   <= 32'(ADDR_INIT);
      r_req_addr <= '0;
      r_req_len  <= '0;
      r_pend     <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase

      if (r_state == ST_IDLE && w_launch) begin
        r_req_len  <= w_len_eff;
        r_req_addr <= r_w_addr;
        r_beats    <= (FIFO_LOG+1)'(w_len_eff);
      end else if (w_pop) begin
        r_beats <= r_beats - 1'b1;
      end

      // A phase change seen during a burst takes effect on its final beat, replacing the increment.
      if (r_state == ST_IDLE) begin
        if (io_bus.pchange) r_w_addr <= io_bus.base_addr;
      end else if (w_last) begin
        if (io_bus.pchange || r_pend) r_w_addr <= io_bus.base_addr;
        else                          r_w_addr <= r_w_addr + r_req_len * 32'(WORD_BYTES);
      end

      if (r_state == ST_IDLE || w_last) r_pend <= 1'b0;
      else if (io_bus.pchange)          r_pend <= 1'b1;
    end
  end

  assign io_bus.din_ready     = !w_full || w_pop;
  assign io_bus.w_addr        = r_w_addr;
  assign io_bus.mgdrive       = w_mg;
  assign io_bus.dram_req      = w_req;
  assign io_bus.dram_req_addr = r_req_addr;
  assign io_bus.dram_req_len  = r_req_len;
  assign io_bus.dram_wdata    = r_mem[r_rd];
  assign io_bus.dram_wvalid   = w_wvalid;
  assign io_bus.fifo_cnt      = r_cnt;

endmodule

// File: tb/tb_dram_write_ctrl.sv
// Scoreboard bench for dram_write_ctrl: directed bursts, backpressure, phase change, reset.
module tb_dram_write_ctrl;
  localparam int DATA_W      = 512;
  localparam int WORD_BYTES  = 64;
  localparam int FIFO_LOG    = 7;
  localparam int MAX_WBLOCKS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_write_ctrl_if #(.DATA_W(DATA_W), .FIFO_LOG(FIFO_LOG)) bus ();

  dram_write_ctrl #(
    .DATA_W(DATA_W), .WORD_BYTES(WORD_BYTES), .FIFO_LOG(FIFO_LOG),
    .MAX_WBLOCKS(MAX_WBLOCKS), .ADDR_INIT(0)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_mg  = 0;
  int word_id = 0;
  bit ack_en = 1'b0;
  bit wr_en = 1'b1;
  bit wr_toggle = 1'b0;
  bit chk_ready = 1'b0;
  logic [DATA_W-1:0] exp_data [$];
  logic [63:0]       exp_req  [$];

  function automatic logic [DATA_W-1:0] mk_word(int id);
    logic [31:0] t;
    t = 32'(id) ^ 32'hA500_0000;
    return {16{t}};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // DRAM-side responder: ack follows an open request when enabled; wready steady or toggling.
  always @(posedge clk) begin
    #1;
    bus.dram_req_ack = ack_en && bus.dram_req;
    bus.dram_wready  = wr_toggle ? !bus.dram_wready : wr_en;
  end

  // Monitor: compares every request handshake and data beat against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if ((bus.dram_req && bus.dram_req_ack) || bus.mgdrive)
        check("mgdrive", 64'(bus.mgdrive), 64'(bus.dram_req && bus.dram_req_ack));
      if (bus.mgdrive) n_mg++;
      if (bus.dram_req && bus.dram_req_ack) begin
        if (exp_req.size() == 0) begin
          check("unexpected_req", 64'(bus.dram_req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [63:0] e;
          e = exp_req.pop_front();
          check("req_addr", 64'(bus.dram_req_addr), 64'(e[63:32]));
          check("req_len",  64'(bus.dram_req_len),  64'(e[31:0]));
        end
      end
      if (bus.dram_wvalid && bus.dram_wready) begin
        n_cmp++;
        if (exp_data.size() == 0) begin
          n_err++;
          $display("FAIL beat_unexpected: got 0x%0h, expected no beat", bus.dram_wdata[31:0]);
        end else begin
          logic [DATA_W-1:0] d;
          d = exp_data.pop_front();
          if (bus.dram_wdata !== d) begin
            n_err++;
            $display("FAIL beat_data: got 0x%0h, expected 0x%0h", bus.dram_wdata[31:0], d[31:0]);
          end
        end
      end
      if (chk_ready)
        check("din_ready", 64'(bus.din_ready),
              64'((bus.fifo_cnt != 8'd128) || (bus.dram_wvalid && bus.dram_wready)));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    exp_data.delete();
    exp_req.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic push_words(int n);
    int done = 0;
    int guard = 0;
    bit acc;
    while (done < n) begin
      bus.din       = mk_word(word_id);
      bus.din_valid = 1'b1;
      @(negedge clk);
      acc = bus.din_ready;
      @(posedge clk); #1;
      if (acc) begin
        exp_data.push_back(mk_word(word_id));
        word_id++;
        done++;
      end
      guard++;
      if (guard > 5000) begin
        check("push_timeout", 64'(done), 64'(n));
        break;
      end
    end
    bus.din_valid = 1'b0;
  endtask

  task automatic wait_handshake();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(bus.dram_req && bus.dram_req_ack) && guard < 300);
    if (guard >= 300) check("handshake_timeout", 64'(guard), 64'd0);
  endtask

  task automatic wait_drain();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((exp_data.size() != 0 || exp_req.size() != 0) && guard < 3000);
    if (guard >= 3000) check("drain_timeout", 64'(exp_data.size()), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    int mg0;
    int guard;
    logic [31:0] nxt [4];
    bus.pchange   = 1'b0;
    bus.base_addr = 32'd0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.w_block   = 32'd16;
    do_reset();

    // Reset state
    check("rst_req",      64'(bus.dram_req), 64'd0);
    check("rst_wvalid",   64'(bus.dram_wvalid), 64'd0);
    check("rst_mgdrive",  64'(bus.mgdrive), 64'd0);
    check("rst_fifo_cnt", 64'(bus.fifo_cnt), 64'd0);
    check("rst_w_addr",   64'(bus.w_addr), 64'd0);
    check("rst_req_addr", 64'(bus.dram_req_addr), 64'd0);
    check("rst_req_len",  64'(bus.dram_req_len), 64'd0);
    check("rst_din_ready", 64'(bus.din_ready), 64'd1);

    // 1: single 16-word burst
    ack_en = 1'b1;
    mg0 = n_mg;
    exp_req.push_back({32'h0, 32'd16});
    push_words(16);
    wait_drain();
    check("t1_w_addr",   64'(bus.w_addr), 64'h400);
    check("t1_fifo_cnt", 64'(bus.fifo_cnt), 64'd0);
    check("t1_mg_count", 64'(n_mg - mg0), 64'd1);

    // 2: sizer tail 8,4,2,1
    do_reset();
    ack_en = 1'b0;
    bus.w_block = 32'd8;
    exp_req.push_back({32'h000, 32'd8});
    exp_req.push_back({32'h200, 32'd4});
    exp_req.push_back({32'h300, 32'd2});
    exp_req.push_back({32'h380, 32'd1});
    push_words(15);
    ack_en = 1'b1;
    nxt[0] = 32'd4; nxt[1] = 32'd2; nxt[2] = 32'd1; nxt[3] = 32'd1;
    for (int i = 0; i < 4; i++) begin
      wait_handshake();
      bus.w_block = nxt[i];
    end
    wait_drain();
    check("t2_w_addr",   64'(bus.w_addr), 64'h3C0);
    check("t2_fifo_cnt", 64'(bus.fifo_cnt), 64'd0);

    // 3: full FIFO with toggling wready
    do_reset();
    ack_en = 1'b0;
    bus.w_block = 32'd16;
    for (int i = 0; i < 11; i++) exp_req.push_back({32'(i * 32'h400), 32'd16});
    push_words(128);
    check("t3_full_cnt",   64'(bus.fifo_cnt), 64'd128);
    check("t3_full_ready", 64'(bus.din_ready), 64'd0);
    chk_ready = 1'b1;
    wr_toggle = 1'b1;
    ack_en    = 1'b1;
    push_words(48);
    wait_drain();
    chk_ready = 1'b0;
    wr_toggle = 1'b0;
    @(posedge clk); #1;
    check("t3_w_addr",   64'(bus.w_addr), 64'h2C00);
    check("t3_fifo_cnt", 64'(bus.fifo_cnt), 64'd0);

    // 4: pchange mid-DATA, then in IDLE with empty FIFO
    do_reset();
    ack_en = 1'b0;
    bus.w_block   = 32'd8;
    bus.base_addr = 32'h1_0000;
    exp_req.push_back({32'h0, 32'd8});
    exp_req.push_back({32'h1_0000, 32'd8});
    push_words(16);
    ack_en = 1'b1;
    wait_handshake();
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.pchange = 1'b1;
    @(posedge clk); #1;
    bus.pchange = 1'b0;
    wait_drain();
    check("t4_w_addr", 64'(bus.w_addr), 64'h1_0200);
    bus.base_addr = 32'h2_0000;
    bus.pchange = 1'b1;
    @(posedge clk); #1;
    bus.pchange = 1'b0;
    check("t4_idle_load", 64'(bus.w_addr), 64'h2_0000);

    // 5: length clamping and held-off ack
    do_reset();
    ack_en = 1'b1;
    bus.w_block = 32'd0;
    exp_req.push_back({32'h0, 32'd1});
    push_words(1);
    wait_drain();
    check("t5_w_addr_len1", 64'(bus.w_addr), 64'h40);
    ack_en = 1'b0;
    bus.w_block = 32'd40;
    push_words(16);
    guard = 0;
    while (!bus.dram_req && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("t5_req_seen", 64'(bus.dram_req), 64'd1);
    bus.w_block = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_req",  64'(bus.dram_req), 64'd1);
      check("t5_hold_addr", 64'(bus.dram_req_addr), 64'h40);
      check("t5_hold_len",  64'(bus.dram_req_len), 64'd16);
    end
    exp_req.push_back({32'h40, 32'd16});
    ack_en = 1'b1;
    wait_drain();
    check("t5_w_addr", 64'(bus.w_addr), 64'h440);

    // 6: asynchronous reset mid-burst
    bus.w_block = 32'd16;
    exp_req.push_back({32'h440, 32'd16});
    push_words(16);
    guard = 0;
    while (!bus.dram_wvalid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("t6_in_data", 64'(bus.dram_wvalid), 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("t6_wvalid",   64'(bus.dram_wvalid), 64'd0);
    check("t6_req",      64'(bus.dram_req), 64'd0);
    check("t6_mgdrive",  64'(bus.mgdrive), 64'd0);
    check("t6_w_addr",   64'(bus.w_addr), 64'd0);
    check("t6_fifo_cnt", 64'(bus.fifo_cnt), 64'd0);
    check("t6_req_addr", 64'(bus.dram_req_addr), 64'd0);
    check("t6_req_len",  64'(bus.dram_req_len), 64'd0);
    exp_data.delete();
    exp_req.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6_post_req", 64'(bus.dram_req), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
